// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops bytes from an 8-bit FIFO and sends each one as a
//               start / 8 data (LSB first) / stop serial frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] C_BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  C_BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  C_BIT_ONE   = BIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP   = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q,  baud_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q,    tx_d;

    logic                w_baud_last;

    assign w_baud_last = (baud_q == C_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_enable && !fifo_empty) begin
                    state_d = S_POP;
                end
            end

            // The FIFO presents the popped byte one cycle after rd_en.
            S_POP: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                shift_d = fifo_dout;
                tx_d    = 1'b0;
                baud_d  = '0;
                state_d = S_START;
            end

            S_START: begin
                if (w_baud_last) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d  = baud_q + C_BAUD_ONE;
                end
            end

            // tx is loaded one bit ahead so the line changes exactly on the boundary.
            S_DATA: begin
                if (w_baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + C_BIT_ONE;
                    if (bit_q == C_BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d  = baud_q + C_BAUD_ONE;
                end
            end

            S_STOP: begin
                tx_d = 1'b1;
                if (w_baud_last) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d  = baud_q + C_BAUD_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign fifo_rd_en = (state_q == S_POP);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_STOP) && w_baud_last;
    assign tx         = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Directed bench for fifo_uart_tx with a FIFO model and a
//               line decoder that checks frames against a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    int vectors = 0;
    int fails   = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_enable = 1'b0;

    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en, tx, busy, frame_done;

    logic       fifo1_empty = 1'b1;
    logic [7:0] fifo1_dout = 8'h00;
    logic       fifo1_rd_en, tx1, busy1, frame_done1;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .tx_enable  (tx_enable),
        .fifo_empty (fifo1_empty),
        .fifo_dout  (fifo1_dout),
        .fifo_rd_en (fifo1_rd_en),
        .tx         (tx1),
        .busy       (busy1),
        .frame_done (frame_done1)
    );

    // FIFO models: registered read data, writes become visible after one edge.
    logic [7:0] mem[$];
    logic [7:0] wq[$];
    logic [7:0] mem1[$];
    logic [7:0] wq1[$];

    always @(posedge clk) begin
        if (fifo_rd_en && mem.size() > 0) begin
            fifo_dout <= mem[0];
            void'(mem.pop_front());
        end
        while (wq.size() > 0) mem.push_back(wq.pop_front());
        fifo_empty <= (mem.size() == 0);

        if (fifo1_rd_en && mem1.size() > 0) begin
            fifo1_dout <= mem1[0];
            void'(mem1.pop_front());
        end
        while (wq1.size() > 0) mem1.push_back(wq1.pop_front());
        fifo1_empty <= (mem1.size() == 0);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder / scoreboard for the CLKS_PER_BIT=4 instance.
    logic [7:0] exp_q[$];
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] exp_byte;
    logic       level = 1'b1;
    logic       in_frame = 1'b0;
    int         idx = 0;
    int         rd_count = 0;
    int         rd_cyc = -100;
    int         end_cyc = -100;
    int         last_gap = 0;
    int         frames = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (in_frame) begin
                in_frame = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end else begin
            if (fifo_rd_en) begin
                rd_count++;
                rd_cyc = cyc;
                vectors++;
                if (fifo_empty !== 1'b0) begin
                    fails++;
                    $display("FAIL rd_while_empty: observed %0h expected 0", fifo_empty);
                end
            end
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                idx      = 0;
                rx_byte  = 8'h00;
                last_gap = cyc - end_cyc - 1;
                vectors++;
                if ((cyc - rd_cyc) != 2) begin
                    fails++;
                    $display("FAIL start_latency: observed %0d expected 2", cyc - rd_cyc);
                end
            end
            if (in_frame) begin
                if (idx % CPB == 0) level = tx;
                else begin
                    vectors++;
                    if (tx !== level) begin
                        fails++;
                        $display("FAIL bit_hold: observed %0h expected %0h", tx, level);
                    end
                end
                if (idx % CPB == 0 && idx / CPB >= 1 && idx / CPB <= 8)
                    rx_byte[idx / CPB - 1] = tx;
                if (idx == 9 * CPB) begin
                    vectors++;
                    if (tx !== 1'b1) begin
                        fails++;
                        $display("FAIL stop_level: observed %0h expected 1", tx);
                    end
                end
                vectors++;
                if (frame_done !== (idx == 10 * CPB - 1)) begin
                    fails++;
                    $display("FAIL frame_done_pos: observed %0h expected %0h",
                             frame_done, (idx == 10 * CPB - 1));
                end
                vectors++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_in_frame: observed %0h expected 1", busy);
                end
                if (idx == 10 * CPB - 1) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL exp_available: observed 0 expected 1");
                    end
                    if (exp_q.size() > 0) begin
                        exp_byte = exp_q.pop_front();
                        vectors++;
                        if (rx_byte !== exp_byte) begin
                            fails++;
                            $display("FAIL frame_byte: observed %0h expected %0h", rx_byte, exp_byte);
                        end
                    end
                    in_frame = 1'b0;
                    end_cyc  = cyc;
                    frames++;
                end else begin
                    idx++;
                end
            end else begin
                vectors++;
                if (frame_done !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_frame_done: observed %0h expected 0", frame_done);
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk); #1;
        wq.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        vectors++;
        if (frames != target) begin
            fails++;
            $display("FAIL frame_count: observed %0d expected %0d", frames, target);
        end
    endtask

    task automatic wait_tx_low(input int budget);
        int n = 0;
        while (tx !== 1'b0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        vectors++;
        if (tx !== 1'b0) begin
            fails++;
            $display("FAIL tx_low_timeout: observed %0h expected 0", tx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b1;
        logic       exp_bit;
        int         n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1) begin fails++; $display("FAIL rst_tx: observed %0h expected 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: observed %0h expected 0", busy); end
        vectors++;
        if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en: observed %0h expected 0", fifo_rd_en); end
        vectors++;
        if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_frame_done: observed %0h expected 0", frame_done); end
        vectors++;
        if (tx1 !== 1'b1) begin fails++; $display("FAIL rst_tx1: observed %0h expected 1", tx1); end
        vectors++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL rst_busy1: observed %0h expected 0", busy1); end
        @(negedge clk); #1;
        reset = 1'b0;

        // Empty FIFO with tx enabled: nothing happens
        tx_enable = 1'b1;
        repeat (50) begin
            @(negedge clk); #1;
            vectors++;
            if (tx !== 1'b1) begin fails++; $display("FAIL empty_tx: observed %0h expected 1", tx); end
            vectors++;
            if (busy !== 1'b0) begin fails++; $display("FAIL empty_busy: observed %0h expected 0", busy); end
            vectors++;
            if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL empty_rd_en: observed %0h expected 0", fifo_rd_en); end
        end
        vectors++;
        if (rd_count != 0) begin fails++; $display("FAIL empty_rd_count: observed %0d expected 0", rd_count); end

        // Single byte
        write_byte(8'hA5);
        wait_frames(1, 200);
        vectors++;
        if (rd_count != 1) begin fails++; $display("FAIL a5_rd_count: observed %0d expected 1", rd_count); end

        // Back-to-back bytes with the minimum gap
        write_byte(8'h3C);
        write_byte(8'hFF);
        wait_frames(3, 400);
        vectors++;
        if (rd_count != 3) begin fails++; $display("FAIL b2b_rd_count: observed %0d expected 3", rd_count); end
        vectors++;
        if (last_gap != 3) begin fails++; $display("FAIL b2b_gap: observed %0d expected 3", last_gap); end

        // Reset during DATA bit 3 aborts the frame; the next byte is sent whole
        write_byte(8'h5A);
        write_byte(8'hC3);
        wait_tx_low(100);
        repeat (4 * CPB + 1) @(negedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b1) begin fails++; $display("FAIL abort_tx: observed %0h expected 1", tx); end
        vectors++;
        if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: observed %0h expected 0", busy); end
        vectors++;
        if (frame_done !== 1'b0) begin fails++; $display("FAIL abort_frame_done: observed %0h expected 0", frame_done); end
        repeat (2) begin
            @(posedge clk); #1;
            vectors++;
            if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL abort_rd_en: observed %0h expected 0", fifo_rd_en); end
            vectors++;
            if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy_hold: observed %0h expected 0", busy); end
        end
        @(negedge clk); #1;
        reset = 1'b0;
        wait_frames(4, 200);
        vectors++;
        if (rd_count != 5) begin fails++; $display("FAIL abort_rd_count: observed %0d expected 5", rd_count); end
        vectors++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL abort_exp_empty: observed %0d expected 0", exp_q.size()); end

        // tx_enable dropped mid-frame: frame completes, then the block holds
        write_byte(8'h96);
        write_byte(8'h42);
        wait_tx_low(100);
        tx_enable = 1'b0;
        wait_frames(5, 200);
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (rd_count != 6) begin fails++; $display("FAIL hold_rd_count: observed %0d expected 6", rd_count); end
        vectors++;
        if (busy !== 1'b0) begin fails++; $display("FAIL hold_busy: observed %0h expected 0", busy); end
        vectors++;
        if (tx !== 1'b1) begin fails++; $display("FAIL hold_tx: observed %0h expected 1", tx); end
        vectors++;
        if (frames != 5) begin fails++; $display("FAIL hold_frames: observed %0d expected 5", frames); end
        @(negedge clk); #1;
        tx_enable = 1'b1;
        wait_frames(6, 200);
        vectors++;
        if (rd_count != 7) begin fails++; $display("FAIL resume_rd_count: observed %0d expected 7", rd_count); end

        // CLKS_PER_BIT=1 instance, byte 0x01
        b1 = 8'h01;
        @(negedge clk); #1;
        wq1.push_back(b1);
        n = 0;
        while (tx1 !== 1'b0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            if (i == 0)      exp_bit = 1'b0;
            else if (i == 9) exp_bit = 1'b1;
            else             exp_bit = b1[i - 1];
            vectors++;
            if (tx1 !== exp_bit) begin
                fails++;
                $display("FAIL cpb1_tx: observed %0h expected %0h", tx1, exp_bit);
            end
            vectors++;
            if (frame_done1 !== (i == 9)) begin
                fails++;
                $display("FAIL cpb1_frame_done: observed %0h expected %0h", frame_done1, (i == 9));
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (tx1 !== 1'b1) begin fails++; $display("FAIL cpb1_after_tx: observed %0h expected 1", tx1); end
        vectors++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL cpb1_after_busy: observed %0h expected 0", busy1); end
        vectors++;
        if (frame_done1 !== 1'b0) begin fails++; $display("FAIL cpb1_after_done: observed %0h expected 0", frame_done1); end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer for the team's 8-bit, 4-deep FIFO.
- Pops bytes from the FIFO, drives fifo_rd_en itself, and serialises each byte onto a UART-style line: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Sits between the FIFO's read port and the chip-level serial output.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range is >= 1.
- DATA_W, 8, data width; fixed at 8 to match the FIFO.

Ports:
- clk  input  1  system clock; all logic is on posedge.
- reset  input  1  synchronous, active-high reset.
- tx_enable  input  1  when high, new frames may start; when low, no new pop is issued.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO registered read data, valid the cycle after the rd_en pulse.
- fifo_rd_en  output  1  one-cycle pop request to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (synchronous, active-high):
  - On a clock edge with reset=1: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, bit and baud counters=0, shift register=0.
  - Reset asserted mid-frame aborts the frame. tx returns high at that edge. No further pop occurs until reset is released.
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If tx_enable=1 and fifo_empty=0, go to POP. Otherwise stay in IDLE.
- POP (1 cycle):
  - fifo_rd_en=1 for exactly this cycle.
  - Go to LOAD.
- LOAD (1 cycle):
  - fifo_dout is now valid; capture it into the shift register.
  - At the exit edge, tx<=0 and the baud counter is cleared.
  - Go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then load tx with shift[0], clear the bit counter, and go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At the end of each bit, shift right and increment the bit counter.
  - After bit index 7, set tx=1 and go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle.
  - Then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width is max(1, clog2(CLKS_PER_BIT)).
  - Wraps to 0 at each bit boundary.
  - With CLKS_PER_BIT=1, every bit lasts exactly one cycle.
- Latency: if the IDLE sample edge is k (fifo_empty=0, tx_enable=1), then fifo_rd_en is high during cycle k→k+1, and tx falls at edge k+2.
- Frame length: tx is low for the start bit starting at edge k+2. The stop bit ends 10*CLKS_PER_BIT cycles later.
- Back-to-back frames:
  - The minimum inter-frame gap is 3 extra tx-high cycles (IDLE, POP, LOAD) after the stop bit.
  - Exactly one fifo_rd_en pulse is issued per frame.
- fifo_rd_en is never asserted while fifo_empty=1. Only this block pops the FIFO, so empty cannot assert between the IDLE sample and POP.
- tx_enable is sampled only in IDLE. Deasserting it mid-frame lets the current frame complete, then the block holds in IDLE.
- FIFO writes during any state have no effect on the frame in flight. The byte is latched in LOAD.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Empty FIFO, tx_enable=1, 50 cycles -> fifo_rd_en never 1; tx=1; busy=0.
- Write 0xA5, tx_enable=1 -> one rd_en pulse; tx falls 2 cycles after the empty sample. Line reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. frame_done pulses once, at cycle 40 of the frame.
- Write 0x3C and 0xFF back-to-back -> exactly 2 rd_en pulses. Frames are 0x3C then 0xFF, separated by stop plus 3 idle-high cycles.
- Reset asserted during DATA bit 3 -> at that edge: tx=1, busy=0, state IDLE. After release with the FIFO still non-empty, the next byte is sent in full.
- tx_enable dropped mid-frame with the FIFO holding 2 bytes -> the current frame completes and frame_done pulses. No further rd_en until tx_enable=1, then the next byte follows.
- CLKS_PER_BIT=1, byte 0x01 -> tx: 0,1,0,0,0,0,0,0,0,1, one cycle each; frame length 10 cycles.
